// File: rtl/downscale_block_param.sv
// Softmax downscale stage: loads one FP32 vector into a fixed-point buffer while tracking
// its maximum, then streams (Zi - Zmax) on an AXI4-Stream master with full backpressure.
module downscale_block_param #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              s_axis_valid_i,
  input  logic [31:0]       s_axis_data_i,
  input  logic              s_axis_last_i,
  output logic              s_axis_ready_o,
  output logic              m_axis_valid_o,
  output logic [DATA_W-1:0] m_axis_data_o,
  output logic              m_axis_last_o,
  input  logic              m_axis_ready_i,
  output logic [CNT_W-1:0]  downscale_number_of_data_o,
  output logic              downscale_done_o,
  output logic              downscale_overflow_o
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_W-1:0]    POS_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]    NEG_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W+23:0]   POS_MAX_W = {{25{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]     LEN_C     = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {LOAD, SUB, DONE} state_t;
  state_t state, state_n;

  // Truncating FP32 -> symmetric saturating fixed point; denormals flush to zero.
  function automatic logic [DATA_W-1:0] fp_to_fix(input logic [31:0] f);
    logic [7:0]        e;
    logic [DATA_W+23:0] wide, mag;
    logic              sat;
    int                sh;
    logic [DATA_W-1:0] res;
    e    = f[30:23];
    wide = {{DATA_W{1'b0}}, 1'b1, f[22:0]};
    sh   = int'({24'd0, e}) - 150 + FRAC_W;
    mag  = '0;
    sat  = (e == 8'hFF) || (sh >= DATA_W);
    if (!sat && sh >= 0)       mag = wide << sh;
    else if (!sat && sh > -24) mag = wide >> (-sh);
    if (mag > POS_MAX_W) sat = 1'b1;
    res = sat ? POS_MAX : mag[DATA_W-1:0];
    if (e == 8'd0) res = '0;
    else if (f[31]) res = -res;
    return res;
  endfunction

  logic [DATA_W-1:0]        mem [MAX_LEN];
  logic signed [DATA_W-1:0] z_fix, zmax, rd_val, diff_sat;
  logic signed [DATA_W:0]   diff;
  logic [CNT_W-1:0]         cnt, len, rd, stored;
  logic                     ready, acc, out_valid, out_last, hs, done, ovf;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         num;

  assign z_fix  = fp_to_fix(s_axis_data_i);
  assign acc    = s_axis_valid_i && ready;
  assign hs     = out_valid && m_axis_ready_i;
  assign stored = (cnt < LEN_C) ? cnt + CNT_W'(1) : cnt;
  assign rd_val = mem[rd[IDX_W-1:0]];

  // Zmax bounds every element, so only the negative side can overflow.
  always_comb begin
    diff     = {rd_val[DATA_W-1], rd_val} - {zmax[DATA_W-1], zmax};
    diff_sat = (diff[DATA_W] && !diff[DATA_W-1]) ? NEG_MIN : diff[DATA_W-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (acc && s_axis_last_i) state_n = SUB;
      SUB:     if (hs && out_last) state_n = DONE;
      DONE:    state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state <= LOAD;
    else            state <= state_n;
  end

  always_ff @(posedge clock_i) begin
    if (acc && cnt < LEN_C) mem[cnt[IDX_W-1:0]] <= z_fix;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      ready     <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      len       <= '0;
      rd        <= '0;
      num       <= '0;
      ovf       <= 1'b0;
      zmax      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      ready <= (state_n == LOAD);
      done  <= (state_n == DONE);
      if (acc) begin
        if (cnt == '0) ovf <= 1'b0;
        if (cnt < LEN_C) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '0 || z_fix > zmax) zmax <= z_fix;
        end else begin
          ovf <= 1'b1;
        end
        if (s_axis_last_i) begin
          num <= stored;
          len <= stored;
          cnt <= '0;
        end
      end
      if (state == SUB) begin
        if (hs) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end
        if ((!out_valid || m_axis_ready_i) && rd != len) begin
          out_valid <= 1'b1;
          out_data  <= diff_sat;
          out_last  <= (rd == len - CNT_W'(1));
          rd        <= rd + CNT_W'(1);
        end
      end
      if (state == DONE) rd <= '0;
    end
  end

  assign s_axis_ready_o             = ready;
  assign m_axis_valid_o             = out_valid;
  assign m_axis_data_o              = out_data;
  assign m_axis_last_o              = out_last;
  assign downscale_number_of_data_o = num;
  assign downscale_done_o           = done;
  assign downscale_overflow_o       = ovf;
endmodule

// File: tb/tb_downscale_block_param.sv
// Directed bench for downscale_block_param: a 64-deep and a 4-deep instance share the
// input stream; sel4 picks which instance's output stream is checked.
module tb_downscale_block_param;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [31:0] s_data = '0;
  logic rdy, v, lst, done, ovf, rdy4, v4, lst4, done4, ovf4;
  logic [15:0] d, d4;
  logic [7:0] num, num4;

  downscale_block_param #(.DATA_W(16), .FRAC_W(8), .MAX_LEN(64), .CNT_W(8)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .s_axis_valid_i(s_valid), .s_axis_data_i(s_data),
    .s_axis_last_i(s_last), .s_axis_ready_o(rdy), .m_axis_valid_o(v), .m_axis_data_o(d),
    .m_axis_last_o(lst), .m_axis_ready_i(m_ready), .downscale_number_of_data_o(num),
    .downscale_done_o(done), .downscale_overflow_o(ovf));

  downscale_block_param #(.DATA_W(16), .FRAC_W(8), .MAX_LEN(4), .CNT_W(8)) dut4 (
    .clock_i(clk), .reset_n_i(rst_n), .s_axis_valid_i(s_valid), .s_axis_data_i(s_data),
    .s_axis_last_i(s_last), .s_axis_ready_o(rdy4), .m_axis_valid_o(v4), .m_axis_data_o(d4),
    .m_axis_last_o(lst4), .m_axis_ready_i(m_ready), .downscale_number_of_data_o(num4),
    .downscale_done_o(done4), .downscale_overflow_o(ovf4));

  bit sel4 = 1'b0;
  logic o_v, o_l, o_rdy, o_done;
  logic [15:0] o_d;
  assign o_v    = sel4 ? v4    : v;
  assign o_l    = sel4 ? lst4  : lst;
  assign o_d    = sel4 ? d4    : d;
  assign o_rdy  = sel4 ? rdy4  : rdy;
  assign o_done = sel4 ? done4 : done;

  int nvec = 0, nerr = 0;
  logic [31:0] frame[$];
  logic [15:0] exp_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!(rdy && rdy4) && t < 100) begin tick(); t++; end
    chk("ready_wait", {31'd0, rdy && rdy4}, 1);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) begin
      wait_ready();
      s_valid = 1'b1; s_data = frame[i]; s_last = (i == frame.size() - 1);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      if (i == 0) chk("ovf_first_beat", {30'd0, ovf, ovf4}, 0);
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
  task automatic collect(input int n, input int mode, input bit full);
    int idx = 0, nd = 0, first = -1;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [15:0] pd = '0;
    for (int k = 0; k < 200; k++) begin
      m_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (pv && !pr) begin
        chk("stall_valid", {31'd0, o_v}, 1);
        chk("stall_data", {16'd0, o_d}, {16'd0, pd});
        chk("stall_last", {31'd0, o_l}, {31'd0, pl});
      end
      if (o_v) chk("in_ready_low", {31'd0, o_rdy}, 0);
      else     chk("idle_zero", {15'd0, o_d, o_l}, 0);
      if (o_v && first < 0) begin
        first = k;
        chk("latency_ok", {31'd0, k <= 2}, 1);
      end
      if (o_v && m_ready) begin
        chk($sformatf("out_data[%0d]", idx), {16'd0, o_d}, {16'd0, exp_d[idx]});
        chk($sformatf("out_last[%0d]", idx), {31'd0, o_l}, {31'd0, idx == exp_d.size() - 1});
        idx++;
      end
      pv = o_v; pr = m_ready; pd = o_d; pl = o_l;
      tick();
      if (o_done) nd++;
      if (idx == n) break;
    end
    chk("handshakes", idx, n);
    m_ready = 1'b1;
    if (full) begin
      repeat (3) begin tick(); if (o_done) nd++; end
      chk("done_pulses", nd, 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, rdy}, 0);
    chk({tag, "_valid"}, {31'd0, v}, 0);
    chk({tag, "_data"}, {16'd0, d}, 0);
    chk({tag, "_last"}, {31'd0, lst}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_num"}, {24'd0, num}, 0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {31'd0, rdy}, 1);

    // basic frame
    frame = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40200000};
    exp_d = '{16'hFE00, 16'h0000, 16'hFB00, 16'hFF80};
    send_frame(); collect(4, 0, 1);
    chk("basic_num", {24'd0, num}, 4);
    chk("basic_ovf", {31'd0, ovf}, 0);

    // same frame under backpressure
    send_frame(); collect(4, 1, 1);
    chk("bp_num", {24'd0, num}, 4);

    // saturation: +/-200 convert to +/-0x7FFF
    frame = '{32'h43480000, 32'hC3480000};
    exp_d = '{16'h0000, 16'h8000};
    send_frame(); collect(2, 0, 1);
    frame = '{32'h43480000, 32'h00000000};
    exp_d = '{16'h0000, 16'h8001};
    send_frame(); collect(2, 0, 1);
    // tiny value truncates to zero; infinity saturates
    frame = '{32'h3A83126F, 32'h3F800000};
    exp_d = '{16'hFF00, 16'h0000};
    send_frame(); collect(2, 0, 1);
    frame = '{32'h7F800000, 32'h3F800000};
    exp_d = '{16'h0000, 16'h8101};
    send_frame(); collect(2, 1, 1);

    // single element then back-to-back two-element frame
    frame = '{32'hBFC00000};
    exp_d = '{16'h0000};
    send_frame(); collect(1, 0, 1);
    chk("single_num", {24'd0, num}, 1);
    frame = '{32'h3F000000, 32'h3E800000};
    exp_d = '{16'h0000, 16'hFFC0};
    send_frame(); collect(2, 0, 1);
    chk("b2b_num", {24'd0, num}, 2);

    // overflow on the 4-deep instance
    sel4 = 1'b1;
    frame = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41100000, 32'h41100000};
    exp_d = '{16'hFD00, 16'hFE00, 16'hFF00, 16'h0000};
    send_frame(); collect(4, 0, 1);
    chk("ovf_num4", {24'd0, num4}, 4);
    chk("ovf_flag4", {31'd0, ovf4}, 1);
    chk("ovf_num64", {24'd0, num}, 6);
    chk("ovf_flag64", {31'd0, ovf}, 0);
    frame = '{32'h3F000000, 32'h3E800000};
    exp_d = '{16'h0000, 16'hFFC0};
    send_frame(); collect(2, 0, 1);
    chk("after_ovf_num4", {24'd0, num4}, 2);
    chk("after_ovf_flag4", {31'd0, ovf4}, 0);
    sel4 = 1'b0;

    // reset after the second output handshake
    frame = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40200000};
    exp_d = '{16'hFE00, 16'h0000, 16'hFB00, 16'hFF80};
    send_frame(); collect(2, 0, 0);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midsub");
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_midsub", {31'd0, rdy}, 1);
    repeat (3) begin
      chk("no_partial_output", {31'd0, v}, 0);
      tick();
    end
    send_frame(); collect(4, 0, 1);
    chk("post_reset_num", {24'd0, num}, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
